// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared types and constants for the instruction fetch stage.
//   - fetch fault codes presented to decode alongside each instruction
//   - fetch FSM state encoding
//   - FIFO entry layout {instr, pc, fault} (66 bits)
package cpu_fetch_pkg;

  localparam logic [1:0] FETCH_FAULT_NONE       = 2'b00;
  localparam logic [1:0] FETCH_FAULT_ACCESS     = 2'b01;
  localparam logic [1:0] FETCH_FAULT_MISALIGNED = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  localparam int ENTRY_W = 66;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  fault;
  } fetch_entry_t;

endpackage

// File: rtl/cpu_fetch_fifo.sv
// cpu_fetch_fifo: small synchronous FIFO holding fetched instruction entries.
//   clk, rst_n : clock / async active-low reset
//   push, din  : write one entry
//   pop        : consume head (caller only pops when count != 0)
//   flush      : drop all entries; a push in the same cycle lands as the
//                only entry afterwards
//   dout       : head entry, forced to zero when empty
//   count      : number of stored entries
module cpu_fetch_fifo #(
  parameter int W     = 66,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  input  logic                         flush,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  // Pointer increment that wraps at DEPTH (DEPTH need not be a power of 2).
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? nxt('0) : '0;
      count  <= CW'(push);
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[flush ? '0 : wr_ptr] <= din;
  end

  assign dout = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/cpu_fetch.sv
// cpu_fetch: instruction fetch stage feeding the decoder.
//   clk, rst_n                     : clock / async active-low reset
//   imem_req_valid/addr/ready      : in-order word read requests (addr = PC)
//   imem_resp_valid/data/err       : read responses, in request order
//   redirect, redirect_pc          : flush and restart fetch at redirect_pc
//   instr_valid/instr/instr_pc/
//   instr_fault, instr_ready       : FIFO head handshake to decode
// Requests are issued under a credit limit so buffered + in-flight words
// never exceed FIFO_DEPTH, which means responses never need backpressure.
module cpu_fetch
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [1:0]  instr_fault,
  input  logic        instr_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int UW = CW + 1;

  fetch_state_e         state;
  logic [31:0]          pc, resp_pc;
  logic [CW-1:0]        outstanding, discard, count;
  logic [UW-1:0]        used;
  logic                 pop, req_fire, keep, misaligned, push;
  fetch_entry_t         push_e, head_e;
  logic [ENTRY_W-1:0]   push_w, head_w;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;

  // Credit: a slot freed by this cycle's pop can be reused immediately.
  assign used           = UW'(count) + UW'(outstanding) - UW'(pop);
  assign imem_req_valid = (state == ST_RUN) && !redirect && (used < UW'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign keep       = imem_resp_valid && (discard == '0);
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  // On redirect the FIFO is flushed; a misaligned target is reported as a
  // single synthetic entry loaded in the same flush.
  always_comb begin
    push   = 1'b0;
    push_e = '0;
    if (redirect) begin
      push         = misaligned;
      push_e.instr = 32'h0;
      push_e.pc    = redirect_pc;
      push_e.fault = FETCH_FAULT_MISALIGNED;
    end else begin
      push         = keep;
      push_e.instr = imem_resp_data;
      push_e.pc    = resp_pc;
      push_e.fault = imem_resp_err ? FETCH_FAULT_ACCESS : FETCH_FAULT_NONE;
    end
  end

  assign push_w = push_e;

  cpu_fetch_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_w),
    .pop   (pop & !redirect),
    .flush (redirect),
    .dout  (head_w),
    .count (count)
  );

  assign head_e      = fetch_entry_t'(head_w);
  assign instr       = head_e.instr;
  assign instr_pc    = head_e.pc;
  assign instr_fault = head_e.fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      state       <= misaligned ? ST_HALT : ST_RUN;
      pc          <= redirect_pc;
      resp_pc     <= redirect_pc;
      // Every word still in flight belongs to the old stream.
      outstanding <= outstanding - CW'(imem_resp_valid);
      discard     <= outstanding - CW'(imem_resp_valid);
    end else begin
      if (req_fire) pc <= pc + 32'd4;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      if (imem_resp_valid) begin
        if (discard != '0) begin
          discard <= discard - CW'(1);
        end else begin
          resp_pc <= resp_pc + 32'd4;
          if (imem_resp_err) begin
            // Words requested after the faulting one are dropped so the
            // faulting entry is the last one decode sees.
            state   <= ST_HALT;
            discard <= outstanding + CW'(req_fire) - CW'(1);
          end
        end
      end
    end
  end

endmodule
